conv_seq_ctrl: RTL and testbench

- Sequencer that feeds the K_DIM x K_DIM multiplier array.
- Accepts a kernel stream and an image stream from two DMA AXI-stream channels.
- Holds the kernel coefficients steady on the kernel bus.
- Buffers one I_DIM x I_DIM image, then replays it pixel by pixel to the array's image channel, row-major, with (m,n) coordinates in user and last on the final pixel.

---
 rtl/conv_seq_ctrl_pkg.sv | 35 +++
 rtl/conv_seq_ctrl_seq_img_buf.sv | 26 ++
 rtl/conv_seq_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_conv_seq_ctrl.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_seq_ctrl_pkg.sv
// Shared types and helpers for the convolution sequencer.
// Optional feature macro: SEQ_CHECK_TLAST_EN (tlast position checking).
package conv_seq_ctrl_pkg;

  // Square of a dimension, used for word counts.
  function automatic int sq(input int x);
    return x * x;
  endfunction

  // Bits needed to index x distinct values (never less than one).
  function automatic int nbits(input int x);
    return (x <= 1) ? 1 : $clog2(x);
  endfunction

  // Default geometry of the multiplier array.
  localparam int K_DIM_DEF  = 3;
  localparam int I_DIM_DEF  = 8;
  localparam int M_BITS_DEF = 16;
  localparam int I_BITS_DEF = nbits(I_DIM_DEF);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_K = 3'd1,
    LOAD_I = 3'd2,
    STREAM = 3'd3,
    DONE   = 3'd4
  } seq_state_t;

  // Pixel coordinate for the default geometry; packs as {m,n} like img_user.
  typedef struct packed {
    logic [I_BITS_DEF-1:0] m;
    logic [I_BITS_DEF-1:0] n;
  } coord_t;

endpackage

// File: rtl/conv_seq_ctrl_seq_img_buf.sv
// Image frame buffer: one synchronous write port, one asynchronous read port.
// Kept as a separate module so it can be swapped for a block RAM later.
module seq_img_buf #(
  parameter int DEPTH  = 64,
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Store a pixel on every write strobe.
  // NOTE: storage arrays get no reset; the loader always rewrites every word before it is read.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/conv_seq_ctrl.sv
// Sequencer feeding the K_DIM x K_DIM multiplier array: latches a kernel,
// buffers one image, then replays it row-major with {m,n} coordinates.
// Optional feature macro: SEQ_CHECK_TLAST_EN enables the sticky len_err flag.
module conv_seq_ctrl
  import conv_seq_ctrl_pkg::*;
#(
  parameter int K_DIM  = K_DIM_DEF,
  parameter int I_DIM  = I_DIM_DEF,
  parameter int M_BITS = M_BITS_DEF,
  parameter int K_SIZE = sq(K_DIM),
  parameter int I_SIZE = sq(I_DIM),
  parameter int I_BITS = nbits(I_DIM)
) (
  input  logic                                     clk,
  input  logic                                     rstn,
  input  logic [M_BITS-1:0]                        s_kernel_tdata,
  input  logic                                     s_kernel_tvalid,
  input  logic                                     s_kernel_tlast,
  output logic                                     s_kernel_tready,
  input  logic [M_BITS-1:0]                        s_img_tdata,
  input  logic                                     s_img_tvalid,
  input  logic                                     s_img_tlast,
  output logic                                     s_img_tready,
  output logic [K_DIM-1:0][K_DIM-1:0][M_BITS-1:0]  kernel_data,
  output logic                                     kernel_valid,
  output logic [M_BITS-1:0]                        img_data,
  output logic [1:0][I_BITS-1:0]                   img_user,
  output logic                                     img_last,
  output logic                                     img_valid,
  input  logic                                     img_ready,
  output logic                                     busy,
  output logic                                     frame_done,
  output logic                                     len_err
);

  localparam int K_W = nbits(K_SIZE);
  localparam int P_W = 2 * I_BITS;

  seq_state_t        state, state_nxt;
  logic [K_W-1:0]    k_cnt;
  logic [P_W-1:0]    p_cnt;
  logic [I_BITS-1:0] row_cnt, col_cnt;
  logic [M_BITS-1:0] buf_rdata;
  logic              buf_we;
  logic              k_last, p_last, col_last;

  assign k_last   = (k_cnt == K_W'(K_SIZE - 1));
  assign p_last   = (p_cnt == P_W'(I_SIZE - 1));
  assign col_last = (col_cnt == I_BITS'(I_DIM - 1));
  assign buf_we   = (state == LOAD_I) && s_img_tvalid;

  seq_img_buf #(
    .DEPTH  (I_SIZE),
    .WIDTH  (M_BITS),
    .ADDR_W (P_W)
  ) u_img_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (p_cnt),
    .wdata (s_img_tdata),
    .raddr (p_cnt),
    .rdata (buf_rdata)
  );

  // State register.
  // NOTE: clocked blocks use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode and handshake/stream outputs.
  // NOTE: every output gets a default first so no path leaves a latch behind.
  always_comb begin
    state_nxt       = state;
    s_kernel_tready = 1'b0;
    s_img_tready    = 1'b0;
    img_valid       = 1'b0;
    img_data        = '0;
    img_user        = '0;
    img_last        = 1'b0;
    frame_done      = 1'b0;
    busy            = (state != IDLE);
    case (state)
      IDLE: begin
        // Kernel has priority; an image without a kernel keeps waiting.
        if (s_kernel_tvalid)                   state_nxt = LOAD_K;
        else if (s_img_tvalid && kernel_valid) state_nxt = LOAD_I;
      end
      LOAD_K: begin
        s_kernel_tready = 1'b1;
        if (s_kernel_tvalid && k_last) state_nxt = IDLE;
      end
      LOAD_I: begin
        s_img_tready = 1'b1;
        if (s_img_tvalid && p_last) state_nxt = STREAM;
      end
      STREAM: begin
        // Outputs follow the pixel counter, which only moves on handshake,
        // so they stay stable while the array stalls.
        img_valid   = 1'b1;
        img_data    = buf_rdata;
        img_user[1] = row_cnt;
        img_user[0] = col_cnt;
        img_last    = p_last;
        if (img_ready && p_last) state_nxt = DONE;
      end
      DONE: begin
        frame_done = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Kernel capture: word k lands at [k/K_DIM][k%K_DIM]; valid drops when a new load starts.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      kernel_data  <= '0;
      kernel_valid <= 1'b0;
      k_cnt        <= '0;
    end else begin
      if (state == IDLE && s_kernel_tvalid) kernel_valid <= 1'b0;
      if (state == LOAD_K && s_kernel_tvalid) begin
        for (int r = 0; r < K_DIM; r++) begin
          for (int c = 0; c < K_DIM; c++) begin
            if (k_cnt == K_W'(r * K_DIM + c)) kernel_data[r][c] <= s_kernel_tdata;
          end
        end
        if (k_last) begin
          k_cnt        <= '0;
          kernel_valid <= 1'b1;
        end else begin
          k_cnt <= k_cnt + 1'b1;
        end
      end
    end
  end

  // Pixel counters: write address during LOAD_I, replay position and {m,n} during STREAM.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      p_cnt   <= '0;
      row_cnt <= '0;
      col_cnt <= '0;
    end else begin
      case (state)
        LOAD_I: begin
          if (s_img_tvalid) p_cnt <= p_last ? '0 : p_cnt + 1'b1;
        end
        STREAM: begin
          if (img_ready) begin
            if (p_last) begin
              p_cnt   <= '0;
              row_cnt <= '0;
              col_cnt <= '0;
            end else begin
              p_cnt <= p_cnt + 1'b1;
              if (col_last) begin
                col_cnt <= '0;
                row_cnt <= row_cnt + 1'b1;
              end else begin
                col_cnt <= col_cnt + 1'b1;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SEQ_CHECK_TLAST_EN
  // Sticky flag for tlast arriving early, late, or not at all.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      len_err <= 1'b0;
    end else begin
      if (state == LOAD_K && s_kernel_tvalid && (s_kernel_tlast != k_last)) len_err <= 1'b1;
      if (state == LOAD_I && s_img_tvalid && (s_img_tlast != p_last))       len_err <= 1'b1;
    end
  end
`else
  logic unused_tlast;
  assign unused_tlast = s_kernel_tlast ^ s_img_tlast;
  assign len_err      = 1'b0;
`endif

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Self-checking bench for conv_seq_ctrl: a vector table for load/arbitration,
// a scoreboard for streamed pixels, and hand-written reset/tlast sequences.
module tb_conv_seq_ctrl;
  import conv_seq_ctrl_pkg::*;

  localparam int K_DIM  = 3;
  localparam int I_DIM  = 8;
  localparam int M_BITS = 16;
  localparam int I_SIZE = 64;
  localparam int I_BITS = 3;

  logic                                    clk = 1'b0;
  logic                                    rstn;
  logic [M_BITS-1:0]                       s_kernel_tdata;
  logic                                    s_kernel_tvalid, s_kernel_tlast, s_kernel_tready;
  logic [M_BITS-1:0]                       s_img_tdata;
  logic                                    s_img_tvalid, s_img_tlast, s_img_tready;
  logic [K_DIM-1:0][K_DIM-1:0][M_BITS-1:0] kernel_data;
  logic                                    kernel_valid;
  logic [M_BITS-1:0]                       img_data;
  logic [1:0][I_BITS-1:0]                  img_user;
  logic                                    img_last, img_valid, img_ready;
  logic                                    busy, frame_done, len_err;

  conv_seq_ctrl dut (
    .clk(clk), .rstn(rstn),
    .s_kernel_tdata(s_kernel_tdata), .s_kernel_tvalid(s_kernel_tvalid),
    .s_kernel_tlast(s_kernel_tlast), .s_kernel_tready(s_kernel_tready),
    .s_img_tdata(s_img_tdata), .s_img_tvalid(s_img_tvalid),
    .s_img_tlast(s_img_tlast), .s_img_tready(s_img_tready),
    .kernel_data(kernel_data), .kernel_valid(kernel_valid),
    .img_data(img_data), .img_user(img_user), .img_last(img_last),
    .img_valid(img_valid), .img_ready(img_ready),
    .busy(busy), .frame_done(frame_done), .len_err(len_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic              kv;
    logic [M_BITS-1:0] kd;
    logic              iv;
    logic              exp_kr, exp_ir, exp_kval, exp_busy;
  } vec_t;

  typedef struct {
    logic [M_BITS-1:0] data;
    coord_t            c;
    logic              last;
  } pix_t;

  vec_t vecs[13];
  pix_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive n image words base+i; expected pixels are pushed as each word is handed over.
  task automatic load_image(input int base, input int n, input int tlast_idx);
    pix_t p;
    s_img_tvalid = 1'b1;
    for (int i = 0; i < n; i++) begin
      int budget = 20;
      s_img_tdata = M_BITS'(base + i);
      s_img_tlast = (i == tlast_idx);
      while (!s_img_tready && budget > 0) begin
        step();
        budget--;
      end
      if (budget == 0) begin
        check("img_tready_timeout", 0, 1);
        break;
      end
      p.data = M_BITS'(base + i);
      p.c.m  = I_BITS'(i / I_DIM);
      p.c.n  = I_BITS'(i % I_DIM);
      p.last = (i == I_SIZE - 1);
      sb.push_back(p);
      step();
    end
    s_img_tvalid = 1'b0;
    s_img_tlast  = 1'b0;
  endtask

  task automatic load_kernel(input int base, input int tlast_idx);
    s_kernel_tvalid = 1'b1;
    for (int k = 0; k < K_DIM * K_DIM; k++) begin
      int budget = 20;
      s_kernel_tdata = M_BITS'(base + k);
      s_kernel_tlast = (k == tlast_idx);
      while (!s_kernel_tready && budget > 0) begin
        step();
        budget--;
      end
      if (budget == 0) begin
        check("k_tready_timeout", 0, 1);
        break;
      end
      step();
    end
    s_kernel_tvalid = 1'b0;
    s_kernel_tlast  = 1'b0;
    check("kernel_valid_latency", kernel_valid, 1);
  endtask

  // Consume one frame; toggle=1 alternates img_ready 0/1 and checks held outputs.
  task automatic stream_frame(input bit toggle);
    int                popped = 0;
    int                budget = 400;
    int                cyc = 0;
    bit                have_hold = 0;
    logic [M_BITS-1:0] h_data;
    logic [5:0]        h_user;
    logic              h_last;
    pix_t              e;
    while (popped < I_SIZE && budget > 0) begin
      img_ready = toggle ? cyc[0] : 1'b1;
      if (have_hold) begin
        check("hold_valid", img_valid, 1);
        check("hold_data", img_data, h_data);
        check("hold_user", img_user, h_user);
        check("hold_last", img_last, h_last);
      end
      have_hold = 0;
      if (img_valid) begin
        if (img_ready) begin
          if (sb.size() == 0) begin
            check("scoreboard_empty", 1, 0);
          end else begin
            e = sb.pop_front();
            check("pix_data", img_data, e.data);
            check("pix_user", img_user, e.c);
            check("pix_last", img_last, e.last);
          end
          popped++;
        end else begin
          h_data    = img_data;
          h_user    = img_user;
          h_last    = img_last;
          have_hold = 1;
        end
      end
      step();
      cyc++;
      budget--;
    end
    img_ready = 1'b0;
    if (budget == 0) check("stream_timeout", popped, I_SIZE);
    check("frame_done_pulse", frame_done, 1);
    check("done_no_valid", img_valid, 0);
    step();
    check("frame_done_clear", frame_done, 0);
    check("idle_after_done", busy, 0);
  endtask

  initial begin
    // Load/arbitration table: kernel and image both valid; kernel must win.
    vecs[0] = '{kv: 1'b0, kd: '0, iv: 1'b0, exp_kr: 1'b0, exp_ir: 1'b0, exp_kval: 1'b0, exp_busy: 1'b0};
    vecs[1] = '{kv: 1'b1, kd: 16'd1, iv: 1'b1, exp_kr: 1'b0, exp_ir: 1'b0, exp_kval: 1'b0, exp_busy: 1'b0};
    for (int k = 0; k < 9; k++)
      vecs[2 + k] = '{kv: 1'b1, kd: 16'(k + 1), iv: 1'b1,
                      exp_kr: 1'b1, exp_ir: 1'b0, exp_kval: 1'b0, exp_busy: 1'b1};
    vecs[11] = '{kv: 1'b0, kd: '0, iv: 1'b1, exp_kr: 1'b0, exp_ir: 1'b0, exp_kval: 1'b1, exp_busy: 1'b0};
    vecs[12] = '{kv: 1'b0, kd: '0, iv: 1'b0, exp_kr: 1'b0, exp_ir: 1'b1, exp_kval: 1'b1, exp_busy: 1'b1};

    rstn = 1'b0;
    s_kernel_tdata = '0; s_kernel_tvalid = 1'b0; s_kernel_tlast = 1'b0;
    s_img_tdata = '0; s_img_tvalid = 1'b0; s_img_tlast = 1'b0;
    img_ready = 1'b0;
    repeat (3) step();

    check("rst_kernel_valid", kernel_valid, 0);
    check("rst_kernel_data", kernel_data, 0);
    check("rst_img_valid", img_valid, 0);
    check("rst_img_data", img_data, 0);
    check("rst_busy", busy, 0);
    check("rst_len_err", len_err, 0);
    rstn = 1'b1;
    step();

    // Kernel 1..9 with image contending.
    for (int i = 0; i < 13; i++) begin
      s_kernel_tvalid = vecs[i].kv;
      s_kernel_tdata  = vecs[i].kd;
      s_kernel_tlast  = (i == 10);
      s_img_tvalid    = vecs[i].iv;
      check($sformatf("v%0d_k_tready", i), s_kernel_tready, vecs[i].exp_kr);
      check($sformatf("v%0d_i_tready", i), s_img_tready, vecs[i].exp_ir);
      check($sformatf("v%0d_kvalid", i), kernel_valid, vecs[i].exp_kval);
      check($sformatf("v%0d_busy", i), busy, vecs[i].exp_busy);
      step();
    end
    check("k00", kernel_data[0][0], 1);
    check("k12", kernel_data[1][2], 6);
    check("k22", kernel_data[2][2], 9);

    // Frame 1: pixels 0..63, array always ready.
    load_image(0, I_SIZE, I_SIZE - 1);
    check("img_latency_valid", img_valid, 1);
    check("img_first_user", img_user, 0);
    stream_frame(1'b0);

    // Frame 2: held kernel reused, img_ready toggling.
    check("kernel_retained", kernel_valid, 1);
    load_image(100, I_SIZE, I_SIZE - 1);
    stream_frame(1'b1);
    check("kernel_retained2", kernel_valid, 1);
    check("scoreboard_drained", sb.size(), 0);

    // Reset in the middle of an image load.
    load_image(200, 30, -1);
    check("mid_load_busy", busy, 1);
    rstn = 1'b0;
    #1;
    check("arst_kernel_valid", kernel_valid, 0);
    check("arst_kernel_data", kernel_data, 0);
    check("arst_busy", busy, 0);
    check("arst_img_tready", s_img_tready, 0);
    check("arst_img_valid", img_valid, 0);
    sb.delete();
    step();
    rstn = 1'b1;
    s_img_tvalid = 1'b1;
    s_img_tdata  = 16'h55;
    for (int i = 0; i < 8; i++) begin
      step();
      check("nokernel_tready", s_img_tready, 0);
      check("nokernel_busy", busy, 0);
    end
    s_img_tvalid = 1'b0;
    step();

    // Kernel with tlast on the fifth word, then a correctly framed image.
    load_kernel(300, 4);
    check("k22_after_bad_tlast", kernel_data[2][2], 308);
`ifdef SEQ_CHECK_TLAST_EN
    check("len_err_set", len_err, 1);
`else
    check("len_err_tied", len_err, 0);
`endif
    load_image(400, I_SIZE, I_SIZE - 1);
    stream_frame(1'b0);
`ifdef SEQ_CHECK_TLAST_EN
    check("len_err_sticky", len_err, 1);
`else
    check("len_err_tied2", len_err, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Absolute time limit in case a sequence stalls.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
